diff_rx: RTL
============

# diff_rx

Pulse-width-coded serial receiver: the receive end of the single-wire link driven by the team's `diff_tx` encoder. It watches the idle-high line, measures the low time of each symbol, classifies it as SYNC, ZERO or ONE, and assembles 26-bit frames MSB first. It emits a one-cycle `valid_out` with the frame, or a one-cycle `error_out` on any protocol violation. It sits on the receiving board directly behind the input pin, so its input is asynchronous.

## Interface
- `DATA_PERIOD`, 20: nominal symbol period in clk cycles; must match the transmitter.
- `ZERO_MAX_LOW`, 7: a low time of `MIN_LOW`..7 cycles decodes as ZERO (nominal 5).
- `ONE_MIN_LOW`, 13: a low time of 13..`DATA_PERIOD`-1 cycles decodes as ONE (nominal 15); `ZERO_MAX_LOW`+1..`ONE_MIN_LOW`-1 decodes as SYNC (nominal 10).
- `MIN_LOW`, 2: a shorter low time is a glitch and raises an error.
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  reset, synchronous and active-high.
- `data_in`  in  1  raw line, asynchronous, idle high.
- `data_out`  out  26  last good frame; bit 25 is the first bit received.
- `valid_out`  out  1  one-cycle strobe: `data_out` updated this cycle.
- `error_out`  out  1  one-cycle strobe: frame aborted.

## Operation
- **Input conditioning**
  - `data_in` passes through a 2-flop synchronizer; both flops reset to 1.
  - `line` is the synchronizer output and `line_d` is `line` delayed one cycle.
  - Fall = `line_d & ~line`. Rise = `~line_d & line`.
- **Counters**
  - `low_cnt` counts cycles with `line` low since the last fall. It starts at 1 on the fall and saturates.
  - `per_cnt` counts cycles since the last fall.
  - Both are `$clog2(2*DATA_PERIOD+1)` bits wide.
  - `sym_idx` is 5 bits: 0 = leading SYNC, 1..26 = data bits, 27 = trailing SYNC.
- **States** (`rx_state_t`): IDLE, LOW, HIGH, RECOVER.
  - **IDLE**: on fall, go to LOW with `low_cnt`=1, `per_cnt`=1, `sym_idx`=0.
  - **LOW**
    - If `low_cnt` reaches `DATA_PERIOD` with no rise: error.
    - On rise, classify `low_cnt`.
    - `sym_idx`=0 must be SYNC. 1..26 must be ZERO/ONE, shifted into the shift register at the LSB. 27 must be SYNC.
    - Any mismatch or glitch: error.
    - If `sym_idx`=27 and the symbol is SYNC: load `data_out` from the shift register, pulse `valid_out`, go to IDLE.
    - Otherwise go to HIGH.
  - **HIGH**
    - On fall, go to LOW: `sym_idx`+1, `low_cnt`=1, `per_cnt`=1.
    - If `per_cnt` exceeds `DATA_PERIOD + DATA_PERIOD/2` (30): error.
    - A fall with `per_cnt` < `DATA_PERIOD/2` is also an error.
  - **Error**: pulse `error_out`, leave `data_out` unchanged, go to RECOVER.
  - **RECOVER**: wait for `line` high for `2*DATA_PERIOD` consecutive cycles; any low restarts the count; then go to IDLE.
- Symbol period tolerance is ±50% of `DATA_PERIOD`; symbol classification uses only the low time.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `error_out`=0, state IDLE, shift register 0, counters 0.
- Reset mid-frame discards the partial frame; no strobe is produced.
- Latency from input to `line` is 2 cycles.
- `valid_out` asserts in the cycle after the rise that ends the trailing SYNC low, which is about 3 cycles after the `data_in` rise.
- `valid_out` and `error_out` are each exactly 1 cycle and never asserted together.
- Back-to-back frames: a fall arriving 1 cycle after `valid_out` (state already IDLE) must start a new frame with no loss.
- A fall in the same cycle that `low_cnt` or `per_cnt` hits its limit is an error; the limit check wins.
- A line held low forever gives one `error_out`, then the block stays in RECOVER.

## Structure
- Shared package `diff_pkg`, also imported by `diff_tx` going forward, holds:
  - `FRAME_BITS`=26
  - the `rx_state_t` enum
  - a `symbol_t` enum (SYM_SYNC, SYM_ZERO, SYM_ONE, SYM_BAD)
  - the default period and threshold constants
- One sub-module: `sync_2ff` (parameterized reset value), instanced for `data_in`.
- Classification is a combinational function in `diff_pkg` that takes `low_cnt` and returns `symbol_t`.

## Test plan
- **Single frame**: `diff_tx` drives 26'h2AAAAAA → one `valid_out`, `data_out`=26'h2AAAAAA, `error_out` never asserts.
- **Extremes and back-to-back**: `diff_tx` sends 26'h0000000, 26'h3FFFFFF and 26'h1234567, each triggered one cycle after the transmitter returns to idle → three `valid_out` pulses with matching data.
- **Wrong symbol**: hand-driven frame with a SYNC (10-cycle low) at `sym_idx`=5 → `error_out` pulse, no `valid_out`, `data_out` holds the previous frame, and a clean frame sent after 40 high cycles is received.
- **Stuck low / glitch**: line low for 50 cycles → `error_out` once, in the cycle after `low_cnt` reaches 20. A 1-cycle low pulse in IDLE → glitch `error_out`.
- **High timeout**: the line stays high for 31 cycles after the fall of data bit 3 → `error_out`.
- **Reset mid-frame**: `rst_in` high for 1 cycle during bit 12 → no strobe, outputs return to reset values, and the next full frame decodes correctly.

Source files
------------

// File: rtl/diff_pkg.sv
// Shared definitions for the pulse-width-coded serial link (diff_tx / diff_rx).
// Holds frame size, default timing thresholds, state/symbol enums and the symbol classifier.
package diff_pkg;

   localparam int unsigned FRAME_BITS = 26;

   localparam int unsigned DEF_DATA_PERIOD  = 20;
   localparam int unsigned DEF_ZERO_MAX_LOW = 7;
   localparam int unsigned DEF_ONE_MIN_LOW  = 13;
   localparam int unsigned DEF_MIN_LOW      = 2;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      RECOVER
   } rx_state_t;

   typedef enum logic [1:0] {
      SYM_SYNC,
      SYM_ZERO,
      SYM_ONE,
      SYM_BAD
   } symbol_t;

   // Decode a measured low time into a symbol; anything outside the bands is SYM_BAD.
   function automatic symbol_t classify(input int unsigned low_time,
                                        input int unsigned min_low,
                                        input int unsigned zero_max_low,
                                        input int unsigned one_min_low,
                                        input int unsigned data_period);
      symbol_t sym;
      if (low_time < min_low) begin
         sym = SYM_BAD;
      end else if (low_time <= zero_max_low) begin
         sym = SYM_ZERO;
      end else if (low_time < one_min_low) begin
         sym = SYM_SYNC;
      end else if (low_time < data_period) begin
         sym = SYM_ONE;
      end else begin
         sym = SYM_BAD;
      end
      return sym;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/diff_rx.sv
// Pulse-width-coded serial receiver: measures each symbol's low time, decodes SYNC/ZERO/ONE
// and assembles MSB-first frames framed by a leading and trailing SYNC.
module diff_rx
   import diff_pkg::*;
#(
   parameter int unsigned DATA_PERIOD  = DEF_DATA_PERIOD,
   parameter int unsigned ZERO_MAX_LOW = DEF_ZERO_MAX_LOW,
   parameter int unsigned ONE_MIN_LOW  = DEF_ONE_MIN_LOW,
   parameter int unsigned MIN_LOW      = DEF_MIN_LOW
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   output logic [FRAME_BITS-1:0] data_out,
   output logic                  valid_out,
   output logic                  error_out
);

   localparam int unsigned CNT_W = $clog2(2 * DATA_PERIOD + 1);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] LOW_LIMIT  = CNT_W'(DATA_PERIOD);
   localparam logic [CNT_W-1:0] PER_MAX    = CNT_W'(DATA_PERIOD + DATA_PERIOD / 2);
   localparam logic [CNT_W-1:0] PER_MIN    = CNT_W'(DATA_PERIOD / 2);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(2 * DATA_PERIOD - 1);
   localparam logic [4:0]       LAST_IDX   = 5'(FRAME_BITS + 1);

   logic line;
   logic line_d;
   logic fall;
   logic rise;

   rx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0]      per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]      quiet_cnt_q, quiet_cnt_d;
   logic [4:0]            sym_idx_q, sym_idx_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;

   logic [CNT_W-1:0] low_inc;
   logic [CNT_W-1:0] per_inc;
   symbol_t          sym;
   logic             err;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk(clk_in),
      .rst(rst_in),
      .d  (data_in),
      .q  (line)
   );

   assign fall = line_d & ~line;
   assign rise = ~line_d & line;

   assign low_inc = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + 1'b1;
   assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;

   assign sym = classify(32'(low_cnt_q), MIN_LOW, ZERO_MAX_LOW, ONE_MIN_LOW, DATA_PERIOD);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         line_d      <= 1'b1;
         state_q     <= IDLE;
         low_cnt_q   <= '0;
         per_cnt_q   <= '0;
         quiet_cnt_q <= '0;
         sym_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         line_d      <= line;
         state_q     <= state_d;
         low_cnt_q   <= low_cnt_d;
         per_cnt_q   <= per_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
         sym_idx_q   <= sym_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      low_cnt_d   = low_cnt_q;
      per_cnt_d   = per_cnt_q;
      quiet_cnt_d = quiet_cnt_q;
      sym_idx_d   = sym_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      err         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d   = LOW;
               low_cnt_d = CNT_ONE;
               per_cnt_d = CNT_ONE;
               sym_idx_d = '0;
               shift_d   = '0;
            end
         end

         LOW: begin
            low_cnt_d = line ? low_cnt_q : low_inc;
            per_cnt_d = per_inc;
            // The low-time limit is checked before the rise so a late rise still aborts.
            if (low_cnt_q >= LOW_LIMIT) begin
               err = 1'b1;
            end else if (rise) begin
               if (sym_idx_q == '0) begin
                  if (sym == SYM_SYNC) state_d = HIGH;
                  else                 err     = 1'b1;
               end else if (sym_idx_q == LAST_IDX) begin
                  if (sym == SYM_SYNC) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     err = 1'b1;
                  end
               end else if (sym == SYM_ZERO || sym == SYM_ONE) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], (sym == SYM_ONE)};
                  state_d = HIGH;
               end else begin
                  err = 1'b1;
               end
            end
         end

         HIGH: begin
            per_cnt_d = per_inc;
            if (per_cnt_q > PER_MAX) begin
               err = 1'b1;
            end else if (fall) begin
               if (per_cnt_q < PER_MIN) begin
                  err = 1'b1;
               end else begin
                  state_d   = LOW;
                  sym_idx_d = sym_idx_q + 1'b1;
                  low_cnt_d = CNT_ONE;
                  per_cnt_d = CNT_ONE;
               end
            end
         end

         RECOVER: begin
            if (!line) begin
               quiet_cnt_d = '0;
            end else if (quiet_cnt_q == QUIET_LAST) begin
               state_d = IDLE;
            end else begin
               quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (err) begin
         error_d     = 1'b1;
         state_d     = RECOVER;
         quiet_cnt_d = '0;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign error_out = error_q;

endmodule
